// File: rtl/game_timer_if.sv
// Purpose: bundles the game-FSM control pulses and the elapsed-time bus seen by the screen pipeline.
// Latency: n/a (wiring only).
// Backpressure: none; pulses are single-cycle and outputs are level signals.
interface game_timer_if;
    logic        start;
    logic        stop;
    logic        clear;
    logic [11:0] game_time;
    logic        running;
    logic        sec_tick;
    logic        time_max;

    // Game FSM / test side: issues control pulses, observes the time.
    modport master (
        output start, stop, clear,
        input  game_time, running, sec_tick, time_max
    );

    // Timer side: consumes control pulses, produces the time.
    modport slave (
        input  start, stop, clear,
        output game_time, running, sec_tick, time_max
    );
endinterface

// File: rtl/game_timer.sv
// Purpose: mm:ss elapsed play timer, started/stopped/cleared by the game FSM, frozen for the endgame screen.
// Latency: all outputs registered; a control pulse takes effect on the next edge, first tick CLK_DIV cycles after start.
// Backpressure: none; pulses are always accepted, priority clear > start > stop.
module game_timer #(
    parameter int CLK_DIV     = 65000000,
    parameter int MAX_MINUTES = 59
) (
    input  logic         pclk,
    input  logic         rst,
    game_timer_if.slave  tmr
);
    localparam int             PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [5:0]     MIN_LAST   = 6'(MAX_MINUTES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        STOPPED = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [5:0]     min_q, min_d;
    logic [5:0]     sec_q, sec_d;
    logic           tick_q, tick_d;
    logic           max_q, max_d;
    logic           run_q, run_d;

    // State, prescaler and all outputs are registered together.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            presc_q <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            tick_q  <= 1'b0;
            max_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            tick_q  <= tick_d;
            max_q   <= max_d;
            run_q   <= run_d;
        end
    end

    // Next state and next output values; clear beats start beats stop, and a
    // stop on the wrap cycle suppresses that cycle's increment.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        min_d   = min_q;
        sec_d   = sec_q;
        tick_d  = 1'b0;
        max_d   = max_q;

        if (tmr.clear) begin
            state_d = IDLE;
            presc_d = '0;
            min_d   = '0;
            sec_d   = '0;
            max_d   = 1'b0;
        end else if (tmr.start) begin
            state_d = RUN;
            presc_d = '0;
            min_d   = '0;
            sec_d   = '0;
            max_d   = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (tmr.stop) begin
                        state_d = STOPPED;
                        presc_d = '0;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        if (min_q == MIN_LAST && sec_q == 6'd59) begin
                            // Saturated: hold MAX:59 and freeze instead of wrapping.
                            state_d = STOPPED;
                            max_d   = 1'b1;
                        end else if (sec_q == 6'd59) begin
                            sec_d  = '0;
                            min_d  = min_q + 6'd1;
                            tick_d = 1'b1;
                        end else begin
                            sec_d  = sec_q + 6'd1;
                            tick_d = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                default: ;
            endcase
        end

        run_d = (state_d == RUN);
    end

    assign tmr.game_time = {min_q, sec_q};
    assign tmr.running   = run_q;
    assign tmr.sec_tick  = tick_q;
    assign tmr.time_max  = max_q;
endmodule

// File: tb/tb_game_timer.sv
// Purpose: self-checking bench for game_timer against a total-seconds reference model.
// Latency: model advances on every rising edge; outputs compared on the following falling edge.
// Backpressure: none; stimulus is single-cycle pulses driven on the falling edge.
module tb_game_timer;
    localparam int DIV   = 4;
    localparam int MAXM  = 1;
    localparam int LIMIT = MAXM * 60 + 59;

    logic pclk;
    logic rst;
    int   n_assert;
    int   n_fail;
    int   ticks_seen;

    // Reference model: elapsed time kept as a plain count of seconds.
    int   m_mode;     // 0 idle, 1 run, 2 stopped
    int   m_total;
    int   m_phase;
    bit   m_tick;
    bit   m_max;

    game_timer_if bus();

    game_timer #(.CLK_DIV(DIV), .MAX_MINUTES(MAXM)) dut (
        .pclk (pclk),
        .rst  (rst),
        .tmr  (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    function automatic logic [11:0] secs_to_bus(input int total);
        return {6'(total / 60), 6'(total % 60)};
    endfunction

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_total = 0;
        m_phase = 0;
        m_tick  = 0;
        m_max   = 0;
    endtask

    task automatic model_step(input bit st, input bit sp, input bit cl);
        m_tick = 0;
        if (cl) begin
            m_mode = 0; m_total = 0; m_phase = 0; m_max = 0;
        end else if (st) begin
            m_mode = 1; m_total = 0; m_phase = 0; m_max = 0;
        end else if (m_mode == 1) begin
            if (sp) begin
                m_mode = 2;
            end else if (m_phase == DIV - 1) begin
                m_phase = 0;
                if (m_total == LIMIT) begin
                    m_mode = 2;
                    m_max  = 1;
                end else begin
                    m_total++;
                    m_tick = 1;
                end
            end else begin
                m_phase++;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".time"}, bus.game_time, secs_to_bus(m_total));
        check({tag, ".run"},  12'(bus.running),  12'(m_mode == 1));
        check({tag, ".tick"}, 12'(bus.sec_tick), 12'(m_tick));
        check({tag, ".max"},  12'(bus.time_max), 12'(m_max));
    endtask

    // One clock: drive pulses, let the edge happen, step the model, compare.
    task automatic cycle(input bit st, input bit sp, input bit cl);
        bus.start = st;
        bus.stop  = sp;
        bus.clear = cl;
        @(posedge pclk);
        model_step(st, sp, cl);
        @(negedge pclk);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.clear = 1'b0;
        if (bus.sec_tick === 1'b1) ticks_seen++;
        check_model("cyc");
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        ticks_seen = 0;
        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        bus.clear  = 1'b0;
        rst        = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(negedge pclk);
        check_model("reset");
        rst = 1'b1;
        idle_cycles(3);
        cycle(1'b0, 1'b1, 1'b0);               // stop in IDLE is ignored
        check("idle_stop", {bus.game_time[11:1], bus.running}, 12'h000);

        // Basic count: first tick after DIV cycles, 01:00 after 240
        cycle(1'b1, 1'b0, 1'b0);
        ticks_seen = 0;
        idle_cycles(4);
        check("first_sec", bus.game_time, 12'h001);
        check("first_tick_cnt", 12'(ticks_seen), 12'd1);
        idle_cycles(236);
        check("one_min", bus.game_time, {6'd1, 6'd0});
        check("tick_cnt_60", 12'(ticks_seen), 12'd60);

        // Stop exactly on the wrap cycle at 00:05
        cycle(1'b1, 1'b0, 1'b0);
        idle_cycles(20);
        check("at_5s", bus.game_time, 12'd5);
        idle_cycles(3);
        ticks_seen = 0;
        cycle(1'b0, 1'b1, 1'b0);
        check("stop_wrap_time", bus.game_time, 12'd5);
        check("stop_wrap_tick", 12'(bus.sec_tick), 12'd0);
        check("stop_wrap_run", 12'(bus.running), 12'd0);
        idle_cycles(100);
        check("frozen_time", bus.game_time, 12'd5);
        check("frozen_ticks", 12'(ticks_seen), 12'd0);

        // Saturation at MAX:59
        cycle(1'b1, 1'b0, 1'b0);
        ticks_seen = 0;
        idle_cycles(476);
        check("sat_pre", bus.game_time, {6'd1, 6'd59});
        check("sat_pre_max", 12'(bus.time_max), 12'd0);
        idle_cycles(4);
        check("sat_time", bus.game_time, {6'd1, 6'd59});
        check("sat_max", 12'(bus.time_max), 12'd1);
        check("sat_run", 12'(bus.running), 12'd0);
        check("sat_ticks", 12'(ticks_seen), 12'd119);
        idle_cycles(20);
        check("sat_hold", bus.game_time, {6'd1, 6'd59});

        // Restart from STOPPED with time_max set
        cycle(1'b1, 1'b0, 1'b0);
        check("restart_max", 12'(bus.time_max), 12'd0);
        check("restart_time", bus.game_time, 12'h000);
        check("restart_run", 12'(bus.running), 12'd1);
        idle_cycles(4);
        check("restart_1s", bus.game_time, 12'd1);

        // Clear + start together while STOPPED at 00:07
        idle_cycles(24);
        cycle(1'b0, 1'b1, 1'b0);
        check("stopped_7", bus.game_time, 12'd7);
        cycle(1'b1, 1'b0, 1'b1);
        check("clr_start_time", bus.game_time, 12'h000);
        check("clr_start_run", 12'(bus.running), 12'd0);
        idle_cycles(8);
        check("clr_start_idle", bus.game_time, 12'h000);
        cycle(1'b1, 1'b0, 1'b0);
        idle_cycles(4);
        check("after_clr_1s", bus.game_time, 12'd1);

        // Asynchronous reset mid-run, held through release
        idle_cycles(9);
        #1 rst = 1'b0;
        #1;
        model_reset();
        check("arst_time", bus.game_time, 12'h000);
        check("arst_run", 12'(bus.running), 12'd0);
        check("arst_max", 12'(bus.time_max), 12'd0);
        @(negedge pclk);
        rst = 1'b1;
        idle_cycles(10);
        check("post_rst", bus.game_time, 12'h000);

        // Randomised pulses against the model
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 99) == 0,
                  $urandom_range(0, 149) == 0,
                  $urandom_range(0, 299) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
